// File: rtl/speck_encrypt_iter.sv
// speck_encrypt_iter
// Iterative SPECK128/128 encryption core. It runs one round per clock and
// computes the key schedule on the fly in the same cycle. The current round
// key is streamed out on a side port so that a downstream decrypt block or
// key cache can capture the full round-key set.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   start      request, sampled only while idle
//   plaintext  {x0, y0}
//   key        {l0, k0}
//   busy       high while rounds run and during the done cycle
//   finished   one-cycle pulse when ciphertext becomes valid
//   ciphertext {x, y} after the final round, held until the next result
//   rk_valid   high in every round cycle
//   rk_index   round number of rk_data
//   rk_data    round key used in the current cycle
module speck_encrypt_iter #(
   parameter int WORD_W    = 64,
   parameter int NR_ROUNDS = 32,
   parameter int ALPHA     = 8,
   parameter int BETA      = 3,
   parameter int CTR_W     = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2*WORD_W-1:0]   plaintext,
   input  logic [2*WORD_W-1:0]   key,
   output logic                  busy,
   output logic                  finished,
   output logic [2*WORD_W-1:0]   ciphertext,
   output logic                  rk_valid,
   output logic [CTR_W-1:0]      rk_index,
   output logic [WORD_W-1:0]     rk_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(NR_ROUNDS - 1);

   logic [1:0]        state;
   logic [WORD_W-1:0] x;
   logic [WORD_W-1:0] y;
   logic [WORD_W-1:0] k;
   logic [WORD_W-1:0] l;
   logic [CTR_W-1:0]  ctr;

   logic [WORD_W-1:0] x_next;
   logic [WORD_W-1:0] y_next;
   logic [WORD_W-1:0] k_next;
   logic [WORD_W-1:0] l_next;
   logic              last_round;

   // One round of the cipher and of the key schedule. Rotations are fixed
   // bit rewiring; the round index is mixed into l zero-extended.
   always_comb begin
      x_next = ({x[ALPHA-1:0], x[WORD_W-1:ALPHA]} + y) ^ k;
      y_next = {y[WORD_W-BETA-1:0], y[WORD_W-1:WORD_W-BETA]} ^ x_next;
      l_next = ({l[ALPHA-1:0], l[WORD_W-1:ALPHA]} + k)
               ^ {{(WORD_W-CTR_W){1'b0}}, ctr};
      k_next = {k[WORD_W-BETA-1:0], k[WORD_W-1:WORD_W-BETA]} ^ l_next;
   end

   assign last_round = (ctr == LAST_CTR);

   // Control and datapath registers. A start seen outside IDLE is ignored,
   // and ciphertext only moves on the final round edge so it stays stable
   // for the whole of the next encryption.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         k          <= '0;
         l          <= '0;
         ctr        <= '0;
         ciphertext <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x     <= plaintext[2*WORD_W-1:WORD_W];
                  y     <= plaintext[WORD_W-1:0];
                  l     <= key[2*WORD_W-1:WORD_W];
                  k     <= key[WORD_W-1:0];
                  ctr   <= '0;
                  state <= ROUND;
               end
            end
            ROUND: begin
               x   <= x_next;
               y   <= y_next;
               k   <= k_next;
               l   <= l_next;
               ctr <= ctr + CTR_W'(1);
               if (last_round) begin
                  ciphertext <= {x_next, y_next};
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status and round-key outputs decode registered state only; the round
   // key outputs are forced to zero outside the round phase.
   assign busy     = (state == ROUND) || (state == DONE);
   assign finished = (state == DONE);
   assign rk_valid = (state == ROUND);
   assign rk_index = rk_valid ? ctr : '0;
   assign rk_data  = rk_valid ? k : '0;

endmodule

// File: tb/tb_speck_encrypt_iter.sv
// tb_speck_encrypt_iter
// Self-checking bench for speck_encrypt_iter. Expected ciphertexts and round
// keys come from a plain software SPECK128/128 model inside this file.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_speck_encrypt_iter;

   localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] PT1  = 128'h6c61766975716520_7469206564616d20;
   localparam logic [127:0] CT1  = 128'ha65d985179783265_7860fedf5c570d18;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         busy;
   logic         finished;
   logic [127:0] ciphertext;
   logic         rk_valid;
   logic [5:0]   rk_index;
   logic [63:0]  rk_data;

   int tests_run    = 0;
   int tests_failed = 0;

   speck_encrypt_iter dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .plaintext  (plaintext),
      .key        (key),
      .busy       (busy),
      .finished   (finished),
      .ciphertext (ciphertext),
      .rk_valid   (rk_valid),
      .rk_index   (rk_index),
      .rk_data    (rk_data)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Software SPECK helpers.
   function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
      return (v << n) | (v >> (64 - n));
   endfunction

   function automatic logic [127:0] speck_model(input logic [127:0] pt,
                                                input logic [127:0] kin);
      logic [63:0] mx, my, ml, mk;
      mx = pt[127:64];
      my = pt[63:0];
      ml = kin[127:64];
      mk = kin[63:0];
      for (int i = 0; i < 32; i++) begin
         mx = (ror64(mx, 8) + my) ^ mk;
         my = rol64(my, 3) ^ mx;
         ml = (ror64(ml, 8) + mk) ^ 64'(i);
         mk = rol64(mk, 3) ^ ml;
      end
      return {mx, my};
   endfunction

   function automatic logic [63:0] model_round_key(input logic [127:0] kin,
                                                   input int idx);
      logic [63:0] ml, mk;
      ml = kin[127:64];
      mk = kin[63:0];
      for (int i = 0; i < idx; i++) begin
         ml = (ror64(ml, 8) + mk) ^ 64'(i);
         mk = rol64(mk, 3) ^ ml;
      end
      return mk;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Stimulus helpers: one-cycle reset, and a start accepted on the next
   // rising edge. start_block returns at the first falling edge after the
   // accepting edge.
   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_block(input logic [127:0] pt, input logic [127:0] kin);
      plaintext = pt;
      key       = kin;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Reset state of every output, and idling without start.
   task automatic test_reset();
      int idle_busy;
      idle_busy = 0;
      rst   = 1'b1;
      start = 1'b0;
      plaintext = '0;
      key       = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({busy, finished, rk_valid} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: got %b expected 000", {busy, finished, rk_valid});
      end
      tests_run++;
      if (ciphertext !== 128'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ciphertext: got %h expected 0", ciphertext);
      end
      tests_run++;
      if (rk_index !== 6'd0 || rk_data !== 64'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_rk: got %0d/%h expected 0/0", rk_index, rk_data);
      end
      for (int j = 0; j < 5; j++) begin
         if (busy !== 1'b0) idle_busy++;
         @(negedge clk);
      end
      tests_run++;
      if (idle_busy !== 0) begin
         tests_failed++;
         $display("[TB] FAIL idle_no_start: got %0d busy cycles expected 0", idle_busy);
      end
   endtask

   // Standard vector: latency, busy length and the round-key stream.
   task automatic test_standard();
      int fin_at, fin_cnt, busy_cnt, idx_bad, data_bad, outside_bad, ct_moved;
      logic [127:0] ct_first, ct_fin;
      logic [63:0]  rk0, rk1;
      fin_at = -1; fin_cnt = 0; busy_cnt = 0; idx_bad = 0;
      data_bad = 0; outside_bad = 0; ct_moved = 0;
      ct_fin = '0; rk0 = '0; rk1 = '0;
      start_block(PT1, KEY1);
      ct_first = ciphertext;
      for (int j = 1; j <= 38; j++) begin
         if (finished === 1'b1) begin
            fin_cnt++;
            if (fin_at < 0) begin
               fin_at = j;
               ct_fin = ciphertext;
            end
         end
         if (busy === 1'b1) busy_cnt++;
         if (j <= 32) begin
            if (rk_valid !== 1'b1 || rk_index !== 6'(j - 1)) idx_bad++;
            if (rk_data !== model_round_key(KEY1, j - 1)) data_bad++;
            if (ciphertext !== ct_first) ct_moved++;
            if (j == 1) rk0 = rk_data;
            if (j == 2) rk1 = rk_data;
         end else if (rk_valid !== 1'b0 || rk_index !== 6'd0 || rk_data !== 64'h0) begin
            outside_bad++;
         end
         @(negedge clk);
      end
      tests_run++;
      if (fin_at !== 33) begin
         tests_failed++;
         $display("[TB] FAIL std_latency: got %0d expected 33", fin_at);
      end
      tests_run++;
      if (fin_cnt !== 1) begin
         tests_failed++;
         $display("[TB] FAIL std_finished_count: got %0d expected 1", fin_cnt);
      end
      tests_run++;
      if (ct_fin !== CT1) begin
         tests_failed++;
         $display("[TB] FAIL std_ciphertext: got %h expected %h", ct_fin, CT1);
      end
      tests_run++;
      if (ciphertext !== CT1) begin
         tests_failed++;
         $display("[TB] FAIL std_ciphertext_hold: got %h expected %h", ciphertext, CT1);
      end
      tests_run++;
      if (busy_cnt !== 33) begin
         tests_failed++;
         $display("[TB] FAIL std_busy_len: got %0d expected 33", busy_cnt);
      end
      tests_run++;
      if (idx_bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL rk_index_stream: got %0d bad cycles expected 0", idx_bad);
      end
      tests_run++;
      if (data_bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL rk_data_stream: got %0d bad cycles expected 0", data_bad);
      end
      tests_run++;
      if (rk0 !== 64'h0706050403020100) begin
         tests_failed++;
         $display("[TB] FAIL rk_data_0: got %h expected 0706050403020100", rk0);
      end
      tests_run++;
      if (rk1 !== 64'h37253b31171d0309) begin
         tests_failed++;
         $display("[TB] FAIL rk_data_1: got %h expected 37253b31171d0309", rk1);
      end
      tests_run++;
      if (outside_bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL rk_outside_round: got %0d bad cycles expected 0", outside_bad);
      end
      tests_run++;
      if (ct_moved !== 0) begin
         tests_failed++;
         $display("[TB] FAIL ct_stable_in_round: got %0d changes expected 0", ct_moved);
      end
   endtask

   // start pulses with other data during ROUND cycles 5 and 32 and in DONE.
   task automatic test_start_while_busy();
      int fin_at, fin_cnt;
      logic [127:0] ct_fin;
      fin_at = -1; fin_cnt = 0; ct_fin = '0;
      do_reset();
      start_block(PT1, KEY1);
      for (int j = 1; j <= 40; j++) begin
         if (finished === 1'b1) begin
            fin_cnt++;
            if (fin_at < 0) begin
               fin_at = j;
               ct_fin = ciphertext;
            end
         end
         if (j == 5 || j == 32 || j == 33) begin
            start     = 1'b1;
            plaintext = rand128();
            key       = rand128();
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      tests_run++;
      if (fin_at !== 33) begin
         tests_failed++;
         $display("[TB] FAIL busy_start_latency: got %0d expected 33", fin_at);
      end
      tests_run++;
      if (fin_cnt !== 1) begin
         tests_failed++;
         $display("[TB] FAIL busy_start_pulses: got %0d expected 1", fin_cnt);
      end
      tests_run++;
      if (ct_fin !== CT1 || ciphertext !== CT1) begin
         tests_failed++;
         $display("[TB] FAIL busy_start_ct: got %h/%h expected %h", ct_fin, ciphertext, CT1);
      end
   endtask

   // Reset at round 10 abandons the block; a later start runs normally.
   task automatic test_reset_mid();
      int fin_cnt, fin_at;
      logic [127:0] ct_fin;
      fin_cnt = 0; fin_at = -1; ct_fin = '0;
      start_block(PT1, KEY1);
      for (int j = 1; j < 11; j++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({busy, rk_valid, finished} !== 3'b000 || ciphertext !== 128'h0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_state: got flags %b ct %h expected 000 and 0",
                  {busy, rk_valid, finished}, ciphertext);
      end
      for (int j = 0; j < 40; j++) begin
         if (finished === 1'b1) fin_cnt++;
         @(negedge clk);
      end
      tests_run++;
      if (fin_cnt !== 0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_no_pulse: got %0d pulses expected 0", fin_cnt);
      end
      start_block(PT1, KEY1);
      for (int j = 1; j <= 40; j++) begin
         if (finished === 1'b1 && fin_at < 0) begin
            fin_at = j;
            ct_fin = ciphertext;
         end
         @(negedge clk);
      end
      tests_run++;
      if (fin_at !== 33 || ct_fin !== CT1) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_rerun: got latency %0d ct %h expected 33 %h",
                  fin_at, ct_fin, CT1);
      end
   endtask

   // start held high: one block every 34 cycles, ciphertext steady between.
   task automatic test_back_to_back();
      int pulses[$];
      int p0, p1, p2, bad_ct, unstable;
      bad_ct = 0; unstable = 0;
      do_reset();
      plaintext = PT1;
      key       = KEY1;
      start     = 1'b1;
      @(negedge clk);
      for (int j = 1; j <= 110; j++) begin
         if (finished === 1'b1) begin
            pulses.push_back(j);
            if (ciphertext !== CT1) bad_ct++;
         end
         if (pulses.size() > 0 && ciphertext !== CT1) unstable++;
         @(negedge clk);
      end
      start = 1'b0;
      do_reset();
      p0 = (pulses.size() > 0) ? pulses[0] : -1;
      p1 = (pulses.size() > 1) ? pulses[1] : -1;
      p2 = (pulses.size() > 2) ? pulses[2] : -1;
      tests_run++;
      if (pulses.size() !== 3) begin
         tests_failed++;
         $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", pulses.size());
      end
      tests_run++;
      if (p0 !== 33 || p1 !== 67 || p2 !== 101) begin
         tests_failed++;
         $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d expected 33,67,101", p0, p1, p2);
      end
      tests_run++;
      if (bad_ct !== 0 || unstable !== 0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_ciphertext: got %0d bad/%0d unstable expected 0/0",
                  bad_ct, unstable);
      end
   endtask

   // Random vectors with inputs scrambled every cycle after acceptance.
   task automatic test_input_isolation();
      logic [127:0] pt, kin, exp_ct, ct_fin;
      int fin_at;
      for (int n = 0; n < 4; n++) begin
         pt     = rand128();
         kin    = rand128();
         exp_ct = speck_model(pt, kin);
         fin_at = -1;
         ct_fin = '0;
         start_block(pt, kin);
         for (int j = 1; j <= 40; j++) begin
            if (finished === 1'b1 && fin_at < 0) begin
               fin_at = j;
               ct_fin = ciphertext;
            end
            plaintext = rand128();
            key       = rand128();
            @(negedge clk);
         end
         tests_run++;
         if (fin_at !== 33 || ct_fin !== exp_ct) begin
            tests_failed++;
            $display("[TB] FAIL isolation_%0d: got latency %0d ct %h expected 33 %h",
                     n, fin_at, ct_fin, exp_ct);
         end
      end
   endtask

   initial begin
      test_reset();
      test_standard();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_input_isolation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
